// File: rtl/srfpu_pcpi_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// srfpu_pcpi_sequencer : queued command issue to the SRFPU PCPI port with a
// one-entry response buffer and accept/complete timeouts.      rev 1.0
// ---------------------------------------------------------------------------
module srfpu_pcpi_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  input  logic        flush,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] issued_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_COUNT   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] NOWAIT_LAST  = TW'(15);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   fifo_insn [DEPTH];
  logic [31:0]   fifo_rs1  [DEPTH];
  logic [31:0]   fifo_rs2  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push;

  logic [TW-1:0] timer;
  logic          seen_wait;
  logic          do_issue, do_done, do_timeout, do_release;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign busy      = (state != IDLE) || !empty;
  assign push      = cmd_valid && !full && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_issue   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          do_issue   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Completion wins over either timeout on the same edge.
        if (pcpi_ready) begin
          do_done    = 1'b1;
          state_next = RESP;
        end else if ((!seen_wait && !pcpi_wait && timer == NOWAIT_LAST) ||
                     timer == TIMEOUT_LAST) begin
          do_timeout = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          do_release = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_issue})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_insn[wr_ptr] <= cmd_insn;
      fifo_rs1[wr_ptr]  <= cmd_rs1;
      fifo_rs2[wr_ptr]  <= cmd_rs2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_valid   <= 1'b0;
      pcpi_insn    <= '0;
      pcpi_rs1     <= '0;
      pcpi_rs2     <= '0;
      timer        <= '0;
      seen_wait    <= 1'b0;
      issued_count <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_wr       <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      if (do_issue) begin
        pcpi_valid   <= 1'b1;
        pcpi_insn    <= fifo_insn[rd_ptr];
        pcpi_rs1     <= fifo_rs1[rd_ptr];
        pcpi_rs2     <= fifo_rs2[rd_ptr];
        timer        <= '0;
        seen_wait    <= 1'b0;
        issued_count <= issued_count + 16'd1;
      end
      if (state == BUSY) begin
        timer <= timer + TW'(1);
        if (pcpi_wait) begin
          seen_wait <= 1'b1;
        end
      end
      if (do_done) begin
        pcpi_valid  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_data    <= pcpi_rd;
        rsp_wr      <= pcpi_wr;
        rsp_timeout <= 1'b0;
      end
      if (do_timeout) begin
        pcpi_valid  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_data    <= '0;
        rsp_wr      <= 1'b0;
        rsp_timeout <= 1'b1;
      end
      if (do_release) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srfpu_pcpi_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_srfpu_pcpi_sequencer : randomized bench with an SRFPU responder model
// and an in-order response scoreboard.                         rev 1.0
// ---------------------------------------------------------------------------
module tb_srfpu_pcpi_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] FADD_INSN = 32'h0020F053;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        cmd_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_insn = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        pcpi_wr = 1'b0, pcpi_wait = 1'b0, pcpi_ready = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        cmd_ready, pcpi_valid, rsp_valid, rsp_wr, rsp_timeout, busy;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_data;
  logic [15:0] issued_count;

  srfpu_pcpi_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .flush(flush),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout),
    .busy(busy), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, bound_expired = 0;

  // Scoreboard: responses as {data, wr, timeout}; runs = cycles pcpi_valid stayed high.
  logic [33:0] rsp_q[$], exp_rsp[$];
  int          run_q[$], exp_run[$];
  int          gap_err = 0, hold_err = 0, rises = 0, run_len = 0;
  logic        prev_pv = 1'b0, prev_rv = 1'b0;
  logic [15:0] prev_ic = '0;
  logic [33:0] prev_rsp = '0;
  bit          stray = 1'b0;
  int          rcyc = 0;

  // SRFPU behaviour is selected by insn[11:10]:
  // 0 = ready after insn[3:0]+1 cycles (wait held before that unless insn[5]),
  // 1 = wait, then ready on cycle TIMEOUT, 2 = wait forever, 3 = silent.
  function automatic logic [31:0] ref_rd(input logic [31:0] i, input logic [31:0] a,
                                         input logic [31:0] b);
    if (i == FADD_INSN && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a + b) ^ i;
  endfunction

  function automatic logic ref_wr(input logic [31:0] i, input logic [31:0] a,
                                  input logic [31:0] b);
    if (i[6:0] == 7'h53) return 1'b1;
    return a[0] ^ b[0];
  endfunction

  function automatic logic [33:0] model_rsp(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
    if (i[11:10] < 2'd2) return {ref_rd(i, a, b), ref_wr(i, a, b), 1'b0};
    return {32'h0, 1'b0, 1'b1};
  endfunction

  function automatic int model_run(input logic [31:0] i);
    case (i[11:10])
      2'd0:    return int'(i[3:0]) + 1;
      2'd3:    return 16;
      default: return TIMEOUT;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn(input logic [1:0] kind, input logic nowait,
                                            input logic [3:0] latm1);
    logic [31:0] v;
    v = $urandom;
    v[11:10] = kind;
    v[5] = nowait;
    v[3:0] = latm1;
    return v;
  endfunction

  always @(negedge clk) begin
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_rd    = '0;
    pcpi_wr    = 1'b0;
    if (!pcpi_valid) begin
      rcyc = 0;
      if (stray) begin
        pcpi_ready = 1'b1;
        pcpi_rd    = $urandom;
        pcpi_wr    = 1'b1;
      end
    end else begin
      rcyc++;
      case (pcpi_insn[11:10])
        2'd0: begin
          if (rcyc == int'(pcpi_insn[3:0]) + 1) begin
            pcpi_ready = 1'b1;
            pcpi_rd    = ref_rd(pcpi_insn, pcpi_rs1, pcpi_rs2);
            pcpi_wr    = ref_wr(pcpi_insn, pcpi_rs1, pcpi_rs2);
          end else if (!pcpi_insn[5]) begin
            pcpi_wait = 1'b1;
          end
        end
        2'd1: begin
          if (rcyc == TIMEOUT) begin
            pcpi_ready = 1'b1;
            pcpi_rd    = ref_rd(pcpi_insn, pcpi_rs1, pcpi_rs2);
            pcpi_wr    = ref_wr(pcpi_insn, pcpi_rs1, pcpi_rs2);
          end else begin
            pcpi_wait = 1'b1;
          end
        end
        2'd2:    pcpi_wait = 1'b1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (pcpi_valid) begin
      if (!prev_pv) rises++;
      if (prev_pv && issued_count != prev_ic) gap_err++;
      run_len++;
    end else if (run_len > 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    if (rsp_valid) begin
      if (!prev_rv) rsp_q.push_back({rsp_data, rsp_wr, rsp_timeout});
      else if ({rsp_data, rsp_wr, rsp_timeout} != prev_rsp) hold_err++;
    end
    prev_pv  = pcpi_valid;
    prev_rv  = rsp_valid;
    prev_ic  = issued_count;
    prev_rsp = {rsp_data, rsp_wr, rsp_timeout};
  end

  task automatic clear_sb();
    rsp_q.delete();
    run_q.delete();
    exp_rsp.delete();
    exp_run.delete();
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic push_cmd(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          output logic [15:0] ic_at_acc);
    bit acc, ok;
    ok = 1'b0;
    ic_at_acc = '0;
    cmd_insn = i; cmd_rs1 = a; cmd_rs2 = b; cmd_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      acc = cmd_ready;
      ic_at_acc = issued_count;
      @(negedge clk);
      if (acc) ok = 1'b1;
    end
    cmd_valid = 1'b0;
    if (ok) begin
      exp_rsp.push_back(model_rsp(i, a, b));
      exp_run.push_back(model_run(i));
    end else begin
      bound_expired++;
    end
  endtask

  task automatic wait_rsps(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 2000) begin @(negedge clk); k++; end
    if (rsp_q.size() < n) bound_expired++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || rsp_valid || pcpi_valid) && k < 2000) begin @(negedge clk); k++; end
    if (busy || rsp_valid || pcpi_valid) bound_expired++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !== 97'h0) begin
      n_fail++;
      $display("FAIL reset_pcpi: got v=%b insn=%h rs1=%h rs2=%h, required all 0",
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2);
    end
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_wr, rsp_timeout} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b data=%h wr=%b to=%b, required all 0",
               rsp_valid, rsp_data, rsp_wr, rsp_timeout);
    end
    n_cmp++;
    if ({issued_count, busy, cmd_ready} !== {16'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_status: got count=%h busy=%b cmd_ready=%b, required 0/0/1",
               issued_count, busy, cmd_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fadd();
    logic [15:0] ic;
    clear_sb();
    rsp_ready = 1'b1;
    push_cmd(FADD_INSN, 32'h3F800000, 32'h40000000, ic);
    n_cmp++;
    if (pcpi_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fadd_latency_e0: pcpi_valid=%b, required 0", pcpi_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !==
        {1'b1, FADD_INSN, 32'h3F800000, 32'h40000000}) begin
      n_fail++;
      $display("FAIL fadd_issue_e1: got v=%b insn=%h rs1=%h rs2=%h", pcpi_valid,
               pcpi_insn, pcpi_rs1, pcpi_rs2);
    end
    wait_rsps(1);
    n_cmp++;
    if (rsp_q.size() < 1 || rsp_q[0] !== {32'h40400000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fadd_rsp: got %h, required %h", (rsp_q.size() > 0) ? rsp_q[0] : 34'h0,
               {32'h40400000, 1'b1, 1'b0});
    end
    n_cmp++;
    if (run_q.size() < 1 || run_q[0] !== 4) begin
      n_fail++;
      $display("FAIL fadd_run: got %0d cycles, required 4", (run_q.size() > 0) ? run_q[0] : -1);
    end
    n_cmp++;
    if (issued_count !== 16'd1) begin
      n_fail++;
      $display("FAIL fadd_issued: got %0d, required 1", issued_count);
    end
    wait_idle();
  endtask

  task automatic test_random_stream();
    localparam int N = 10;
    logic [15:0] ic0;
    clear_sb();
    ic0 = issued_count;
    fork
      begin
        logic [15:0] ic;
        int          r;
        logic [1:0]  kind;
        for (int i = 0; i < N; i++) begin
          r = $urandom_range(0, 9);
          kind = (r < 7) ? 2'd0 : (r == 7) ? 2'd3 : (r == 8) ? 2'd1 : 2'd2;
          push_cmd(rand_insn(kind, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))),
                   $urandom, $urandom, ic);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        int k = 0;
        while (rsp_q.size() < N && k < 3000) begin
          rsp_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          k++;
        end
      end
    join
    rsp_ready = 1'b1;
    wait_rsps(N);
    wait_idle();
    n_cmp++;
    if (rsp_q.size() !== N || exp_rsp.size() !== N) begin
      n_fail++;
      $display("FAIL stream_count: got %0d responses, required %0d", rsp_q.size(), N);
    end
    for (int i = 0; i < N && i < rsp_q.size() && i < run_q.size() && i < exp_rsp.size(); i++) begin
      n_cmp++;
      if (rsp_q[i] !== exp_rsp[i]) begin
        n_fail++;
        $display("FAIL stream_rsp[%0d]: got %h, required %h", i, rsp_q[i], exp_rsp[i]);
      end
      n_cmp++;
      if (run_q[i] !== exp_run[i]) begin
        n_fail++;
        $display("FAIL stream_run[%0d]: got %0d cycles, required %0d", i, run_q[i], exp_run[i]);
      end
    end
    n_cmp++;
    if (issued_count !== 16'(ic0 + N)) begin
      n_fail++;
      $display("FAIL stream_issued: got %0d, required %0d", issued_count, ic0 + N);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ic, ic0;
    clear_sb();
    rsp_ready = 1'b1;
    ic0 = issued_count;
    push_cmd(rand_insn(2'd0, 1'b0, 4'd15), $urandom, $urandom, ic);
    for (int i = 0; i < 4; i++) begin
      push_cmd(rand_insn(2'd0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7))),
               $urandom, $urandom, ic);
    end
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL fill_full: got cmd_ready=%b busy=%b, required 0/1", cmd_ready, busy);
    end
    push_cmd(rand_insn(2'd0, 1'b0, 4'($urandom_range(0, 7))), $urandom, $urandom, ic);
    n_cmp++;
    if (ic !== 16'(ic0 + 2)) begin
      n_fail++;
      $display("FAIL fill_fifth_accept: issued_count at accept %0d, required %0d", ic, ic0 + 2);
    end
    wait_rsps(6);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= rsp_q.size() || i >= run_q.size() || rsp_q[i] !== exp_rsp[i] ||
          run_q[i] !== exp_run[i]) begin
        n_fail++;
        $display("FAIL fill_rsp[%0d]: got %h/%0d, required %h/%0d", i,
                 (i < rsp_q.size()) ? rsp_q[i] : 34'h0, (i < run_q.size()) ? run_q[i] : -1,
                 exp_rsp[i], exp_run[i]);
      end
    end
  endtask

  task automatic test_timeouts();
    logic [15:0] ic;
    clear_sb();
    rsp_ready = 1'b1;
    push_cmd(rand_insn(2'd3, 1'b0, 4'($urandom_range(0, 15))), $urandom, $urandom, ic);
    push_cmd(rand_insn(2'd2, 1'b0, 4'($urandom_range(0, 15))), $urandom, $urandom, ic);
    push_cmd(rand_insn(2'd1, 1'b0, 4'($urandom_range(0, 15))), $urandom, $urandom, ic);
    push_cmd(rand_insn(2'd0, 1'b1, 4'd15), $urandom, $urandom, ic);
    wait_rsps(4);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rsp_q.size() || rsp_q[i] !== exp_rsp[i]) begin
        n_fail++;
        $display("FAIL timeout_rsp[%0d]: got %h, required %h", i,
                 (i < rsp_q.size()) ? rsp_q[i] : 34'h0, exp_rsp[i]);
      end
      n_cmp++;
      if (i >= run_q.size() || run_q[i] !== exp_run[i]) begin
        n_fail++;
        $display("FAIL timeout_run[%0d]: got %0d cycles, required %0d", i,
                 (i < run_q.size()) ? run_q[i] : -1, exp_run[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [15:0] ic, ic0;
    logic [33:0] snap;
    int          k, stall_bad, r0;
    clear_sb();
    rsp_ready = 1'b0;
    push_cmd(rand_insn(2'd0, 1'b0, 4'd1), $urandom, $urandom, ic);
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    if (!rsp_valid) bound_expired++;
    snap = {rsp_data, rsp_wr, rsp_timeout};
    ic0 = issued_count;
    r0 = rises;
    n_cmp++;
    if (snap !== exp_rsp[0]) begin
      n_fail++;
      $display("FAIL stall_rsp: got %h, required %h", snap, exp_rsp[0]);
    end
    for (int i = 0; i < 3; i++) push_cmd(rand_insn(2'd0, 1'b0, 4'd2), $urandom, $urandom, ic);
    stray = 1'b1;
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || {rsp_data, rsp_wr, rsp_timeout} !== snap || pcpi_valid ||
          issued_count !== ic0) stall_bad++;
    end
    n_cmp++;
    if (stall_bad !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d cycles disturbed, required 0", stall_bad);
    end
    cmd_insn = $urandom; cmd_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; flush = 1'b0; stray = 1'b0;
    repeat (3) begin void'(exp_rsp.pop_back()); void'(exp_run.pop_back()); end
    n_cmp++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b111) begin
      n_fail++;
      $display("FAIL flush_hold: got busy=%b cmd_ready=%b rsp_valid=%b, required 1/1/1",
               busy, cmd_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, rsp_valid, issued_count} !== {2'b00, ic0} || rises !== r0) begin
      n_fail++;
      $display("FAIL flush_drain: got busy=%b rsp_valid=%b issued=%0d new_issues=%0d, required 0/0/%0d/0",
               busy, rsp_valid, issued_count, rises - r0, ic0);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] ic;
    int          r0;
    clear_sb();
    rsp_ready = 1'b1;
    push_cmd(rand_insn(2'd2, 1'b0, 4'd0), $urandom, $urandom, ic);
    push_cmd(rand_insn(2'd0, 1'b0, 4'd2), $urandom, $urandom, ic);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({pcpi_valid, rsp_valid, issued_count, busy, cmd_ready} !== {2'b00, 16'h0, 2'b01}) begin
      n_fail++;
      $display("FAIL async_reset: got pcpi_valid=%b rsp_valid=%b issued=%0d busy=%b cmd_ready=%b",
               pcpi_valid, rsp_valid, issued_count, busy, cmd_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    r0 = rises;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({pcpi_valid, busy, issued_count} !== 18'h0 || rises !== r0) begin
      n_fail++;
      $display("FAIL reset_no_reissue: got pcpi_valid=%b busy=%b issued=%0d new_issues=%0d",
               pcpi_valid, busy, issued_count, rises - r0);
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (gap_err !== 0) begin
      n_fail++;
      $display("FAIL pcpi_gap: %0d issues without a low cycle, required 0", gap_err);
    end
    n_cmp++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL rsp_stable: %0d response changes while held, required 0", hold_err);
    end
    n_cmp++;
    if (bound_expired !== 0) begin
      n_fail++;
      $display("FAIL wait_bounds: %0d waits expired, required 0", bound_expired);
    end
  endtask

  initial begin
    test_reset();
    test_single_fadd();
    test_random_stream();
    test_back_to_back();
    test_timeouts();
    test_stall_flush();
    test_reset_mid_busy();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
